// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the multi-digit BCD countdown timer.
// Digit limits live here so the top level and the digit cells agree on them.
package bcd_timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  // Under MM:SS the seconds-tens digit only reaches 5; everything else is decimal.
  function automatic logic [BCD_W-1:0] digit_max(input int index, input bit mmss);
    return (mmss && index == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow chain: decrements when enabled, wrapping
// from zero to the digit's own maximum.
import bcd_timer_pkg::*;

module bcd_digit_dec (
  input  logic [BCD_W-1:0] value,
  input  logic [BCD_W-1:0] max,
  input  logic             dec_en,
  output logic [BCD_W-1:0] next_value,
  output logic             is_zero
);

  assign is_zero = (value == '0);

  always_comb begin
    next_value = value;
    if (dec_en) begin
      next_value = is_zero ? max : value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/done control, load
// validation, a one-cycle expiry pulse and optional auto-reload.
import bcd_timer_pkg::*;

module bcd_countdown_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter bit MMSS        = 1'b1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_data,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        clear,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        running,
  output logic                        expired,
  output logic                        done,
  output logic                        error
);

  localparam int W = BCD_W * NUM_DIGITS;

  timer_state_t          state, state_next;
  logic [W-1:0]          count_next, reload, reload_next, dec_count;
  logic                  error_next, expired_next;
  logic [NUM_DIGITS-1:0] dec_en, is_zero, digit_ok;
  logic                  count_zero, load_ok;

  // Digit i borrows only when every lower digit is zero before the tick.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign dec_en[i] = 1'b1;
    end else begin : g_upper
      assign dec_en[i] = dec_en[i-1] & is_zero[i-1];
    end

    bcd_digit_dec u_digit (
      .value      (count[i*BCD_W +: BCD_W]),
      .max        (digit_max(i, MMSS)),
      .dec_en     (dec_en[i]),
      .next_value (dec_count[i*BCD_W +: BCD_W]),
      .is_zero    (is_zero[i])
    );

    assign digit_ok[i] = (load_data[i*BCD_W +: BCD_W] <= digit_max(i, MMSS));
  end

  assign count_zero = &is_zero;
  assign load_ok    = &digit_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      error   <= 1'b0;
      expired <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      reload  <= reload_next;
      error   <= error_next;
      expired <= expired_next;
      running <= (state_next == RUN);
      done    <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    reload_next  = reload;
    error_next   = error;
    expired_next = 1'b0;

    if (clear) begin
      count_next = '0;
      error_next = 1'b0;
      state_next = IDLE;
    end else if (load) begin
      state_next = IDLE;
      if (load_ok) begin
        count_next  = load_data;
        reload_next = load_data;
        error_next  = 1'b0;
      end else begin
        count_next = '0;
        error_next = 1'b1;
      end
    end else if (pause) begin
      if (state == RUN) state_next = PAUSED;
    end else if (start && state != RUN) begin
      if ((state == IDLE || state == PAUSED) && !count_zero && !error) begin
        state_next = RUN;
      end
    end else if (tick && state == RUN) begin
      // A zero count while still running only happens after an auto-reload expiry.
      if (count_zero) begin
        count_next = reload;
      end else begin
        count_next = dec_count;
        if (dec_count == '0) begin
          expired_next = 1'b1;
          if (!(AUTO_RELOAD && reload != '0)) state_next = DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: three timer configurations share one stimulus stream and
// are compared cycle by cycle against a mixed-radix arithmetic reference model.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [15:0] load_data = '0;

  logic [15:0] count_a, count_b, count_c;
  logic        running_a, running_b, running_c;
  logic        expired_a, expired_b, expired_c;
  logic        done_a, done_b, done_c;
  logic        error_a, error_b, error_c;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS(1'b1), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_data(load_data),
    .start(start), .pause(pause), .clear(clear), .count(count_a),
    .running(running_a), .expired(expired_a), .done(done_a), .error(error_a));

  bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS(1'b1), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_data(load_data),
    .start(start), .pause(pause), .clear(clear), .count(count_b),
    .running(running_b), .expired(expired_b), .done(done_b), .error(error_b));

  bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS(1'b0), .AUTO_RELOAD(1'b0)) dut_c (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_data(load_data),
    .start(start), .pause(pause), .clear(clear), .count(count_c),
    .running(running_c), .expired(expired_c), .done(done_c), .error(error_c));

  typedef struct {
    logic [15:0] count;
    logic        running;
    logic        expired;
    logic        done;
    logic        error;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$];
  int   tests = 0;
  int   fails = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int          m_state  [3];
  logic [15:0] m_count  [3];
  logic [15:0] m_reload [3];
  logic        m_error  [3];

  function automatic bit cfg_mmss(input int k);
    return k != 2;
  endfunction

  function automatic bit cfg_ar(input int k);
    return k == 1;
  endfunction

  function automatic int radix(input int i, input bit mmss);
    return (mmss && i == 1) ? 6 : 10;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] v, input bit mmss);
    for (int i = 0; i < 4; i++) begin
      if (int'(v[4*i +: 4]) >= radix(i, mmss)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Count as a plain number of base periods (seconds under MM:SS).
  function automatic int bcd_to_int(input logic [15:0] v, input bit mmss);
    int acc = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      acc += int'(v[4*i +: 4]) * w;
      w   *= radix(i, mmss);
    end
    return acc;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n, input bit mmss);
    logic [15:0] r = '0;
    int rem = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(rem % radix(i, mmss));
      rem         = rem / radix(i, mmss);
    end
    return r;
  endfunction

  task automatic model_step(input int k, input logic r, c, l, input logic [15:0] ld,
                            input logic s, p, t, output exp_t e);
    int v;
    e.expired = 1'b0;
    if (r) begin
      m_state[k] = M_IDLE; m_count[k] = '0; m_reload[k] = '0; m_error[k] = 1'b0;
    end else if (c) begin
      m_state[k] = M_IDLE; m_count[k] = '0; m_error[k] = 1'b0;
    end else if (l) begin
      m_state[k] = M_IDLE;
      if (bcd_valid(ld, cfg_mmss(k))) begin
        m_count[k] = ld; m_reload[k] = ld; m_error[k] = 1'b0;
      end else begin
        m_count[k] = '0; m_error[k] = 1'b1;
      end
    end else if (p) begin
      if (m_state[k] == M_RUN) m_state[k] = M_PAUSED;
    end else if (s && m_state[k] != M_RUN) begin
      if ((m_state[k] == M_IDLE || m_state[k] == M_PAUSED) && m_count[k] != 0 && !m_error[k])
        m_state[k] = M_RUN;
    end else if (t && m_state[k] == M_RUN) begin
      v = bcd_to_int(m_count[k], cfg_mmss(k));
      if (v == 0) begin
        m_count[k] = m_reload[k];
      end else begin
        v = v - 1;
        m_count[k] = int_to_bcd(v, cfg_mmss(k));
        if (v == 0) begin
          e.expired = 1'b1;
          if (!(cfg_ar(k) && m_reload[k] != 0)) m_state[k] = M_DONE;
        end
      end
    end
    e.count   = m_count[k];
    e.running = (m_state[k] == M_RUN);
    e.done    = (m_state[k] == M_DONE);
    e.error   = m_error[k];
  endtask

  task automatic applyStimulus(input logic r, c, l, input logic [15:0] ld,
                               input logic s, p, t);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; load = l; load_data = ld; start = s; pause = p; tick = t;
    model_step(0, r, c, l, ld, s, p, t, e); q_a.push_back(e);
    model_step(1, r, c, l, ld, s, p, t, e); q_b.push_back(e);
    model_step(2, r, c, l, ld, s, p, t, e); q_c.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkDut(input string tag, input exp_t e, input logic [15:0] cnt,
                          input logic run, exp, dn, err);
    checkOutput({tag, ".count"},   cnt,          e.count);
    checkOutput({tag, ".running"}, 16'(run),     16'(e.running));
    checkOutput({tag, ".expired"}, 16'(exp),     16'(e.expired));
    checkOutput({tag, ".done"},    16'(dn),      16'(e.done));
    checkOutput({tag, ".error"},   16'(err),     16'(e.error));
  endtask

  // Monitor: each pending expectation belongs to the edge just taken.
  exp_t ea, eb, ec;
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) begin ea = q_a.pop_front(); checkDut("a", ea, count_a, running_a, expired_a, done_a, error_a); end
    if (q_b.size() > 0) begin eb = q_b.pop_front(); checkDut("b", eb, count_b, running_b, expired_b, done_b, error_b); end
    if (q_c.size() > 0) begin ec = q_c.pop_front(); checkDut("c", ec, count_c, running_c, expired_c, done_c, error_c); end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 16'h0, 0, 0, 1);
  endtask

  task automatic load_start(input logic [15:0] v);
    applyStimulus(0, 0, 1, v, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, 0);
  endtask

  initial begin
    logic        r, c, l, s, p, t;
    logic [15:0] ld;

    applyStimulus(1, 0, 0, 16'h0, 0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 0);
    idle(1);

    // 01:00 counted all the way down
    load_start(16'h0100);
    ticks(60);
    idle(2);

    // invalid load, start refused, recovered by a valid load
    applyStimulus(0, 0, 1, 16'h0170, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, 0);
    applyStimulus(0, 0, 1, 16'h0030, 0, 0, 0);
    idle(1);

    // pause holds the count, including a tick alongside pause
    load_start(16'h0005);
    ticks(2);
    applyStimulus(0, 0, 0, 16'h0, 0, 1, 1);
    ticks(3);
    applyStimulus(0, 0, 0, 16'h0, 1, 0, 0);
    ticks(1);

    // short expiry, then one more tick to exercise auto-reload
    load_start(16'h0002);
    ticks(4);
    idle(1);

    // multi-digit borrow, then clear beating tick
    load_start(16'h1000);
    ticks(1);
    applyStimulus(0, 1, 0, 16'h0, 0, 0, 1);
    idle(1);

    // reset dominates load and tick mid-run
    load_start(16'h0043);
    ticks(1);
    applyStimulus(1, 0, 1, 16'h0123, 0, 0, 1);
    idle(1);

    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 6);
      s = ($urandom_range(0, 99) < 15);
      p = ($urandom_range(0, 99) < 5);
      t = ($urandom_range(0, 99) < 60);
      ld = '0;
      ld[3:0] = 4'($urandom_range(0, 9));
      ld[7:4] = 4'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) ld[15:8] = 8'($urandom);
      if ($urandom_range(0, 19) == 0) ld[3:0] = 4'($urandom_range(10, 15));
      applyStimulus(r, c, l, ld, s, p, t);
    end

    idle(1);
    @(posedge clk);
    #3;
    tests++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", q_a.size() + q_b.size() + q_c.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD countdown timer for the front-panel timer path.
- Generalises the single-digit down counter to NUM_DIGITS cascaded digits. MM:SS mode limits the seconds-tens digit to 0-5.
- Adds a run/pause/done state machine, whole-word load validation with error flag, a one-cycle expiry pulse and optional auto-reload.
- Sits between the 1 Hz tick generator and the 7-segment display driver.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (2-8); digit 0 is least significant.
- MMSS, 1, when 1 digit 1 has maximum value 5; all other digits have maximum value 9. When 0 every digit has maximum value 9.
- AUTO_RELOAD, 0, when 1 the timer reloads the last accepted load value on expiry and keeps running.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  count enable, one-cycle pulse per count period
- load  in  1  load request for load_data
- load_data  in  4*NUM_DIGITS  BCD start value, digit i at bits [4i+3:4i]
- start  in  1  begin or resume counting
- pause  in  1  suspend counting
- clear  in  1  zero the count and return to IDLE
- count  out  4*NUM_DIGITS  current BCD value
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when the count reaches zero
- done  out  1  high in DONE
- error  out  1  sticky flag: last load was invalid

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: count=0, state=IDLE, running=0, expired=0, done=0, error=0, reload register=0.
- States:
  - IDLE: loaded or cleared, not counting.
  - RUN: counting.
  - PAUSED: counting suspended.
  - DONE: count reached zero.
- Per-cycle priority: reset > clear > load > pause > start > tick.
- clear (any state): count=0, error=0, state=IDLE.
- load (any state), all digits within their maximum: count=load_data, reload register=load_data, error=0, state=IDLE.
- load (any state), any digit above its maximum (>9, or >5 for digit 1 when MMSS=1):
  - count=0, error=1, state=IDLE.
  - reload register unchanged.
  - error stays set until the next valid load, clear or reset.
- start: moves IDLE/PAUSED to RUN only when count!=0 and error=0; ignored otherwise. start while in RUN has no effect.
- pause: moves RUN to PAUSED; ignored in other states.
- tick in RUN performs a borrow-chain decrement:
  - Digit 0 always decrements.
  - Digit i>0 decrements only when digits 0..i-1 are all zero before the tick.
  - A digit at 0 that decrements wraps to its maximum (9, or 5 for digit 1 under MMSS).
  - The update takes effect on the same clock edge as tick; there is no pipeline latency.
- Zero reached (post-decrement count==0):
  - expired=1 for exactly the following cycle.
  - AUTO_RELOAD=0: state=DONE, count holds 0.
  - AUTO_RELOAD=1: count=reload register on the next tick instead of decrementing, and the state stays RUN. If the reload register is 0, state=DONE.
- Outputs: running = (state==RUN) and done = (state==DONE), both registered. expired never asserts outside the zero transition.
- tick outside RUN is ignored. A tick in the same cycle as pause is ignored, because pause has priority.
- Reset mid-RUN returns all outputs to their reset values on the next edge.

Decomposition:
- Package bcd_timer_pkg:
  - state enum (IDLE, RUN, PAUSED, DONE), 2-bit encoding.
  - function digit_max(index, mmss) returning 4'd9 or 4'd5.
  - BCD width constant 4.
- Sub-module bcd_digit_dec, instantiated NUM_DIGITS times in a generate loop:
  - Inputs: value, max, dec_en.
  - Outputs: next value, is_zero.
  - The top level builds the borrow chain from the is_zero outputs and keeps all registers and the FSM.

Test Plan (NUM_DIGITS=4, MMSS=1 unless stated):
1. Load 0x0100 (01:00), start, 1 tick -> count=0x0059, running=1; 59 further ticks -> count=0x0000, expired pulses for 1 cycle, done=1, running=0.
2. Load 0x0170 (digit1=7) -> count=0x0000, error=1; start -> state stays IDLE; load 0x0030 -> error=0, count=0x0030.
3. Load 0x0005, start, 2 ticks (count=0x0003), pause, 3 ticks -> count holds 0x0003; start, 1 tick -> 0x0002.
4. AUTO_RELOAD=1: load 0x0002, start, 2 ticks -> expired pulse, count=0x0000 while running=1; next tick -> count=0x0002.
5. MMSS=0, load 0x1000, start, 1 tick -> count=0x0999; assert clear and tick in the same cycle -> count=0x0000, state IDLE.
6. In RUN at 0x0042, assert reset together with load and tick -> count=0, error=0, running=0, done=0 after the edge.
